button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the number of consecutive stable clock cycles needed to accept a level change (legal minimum 2).
REQ-002 Parameter ACTIVE_LOW, default 1, SHALL mean the raw button reads 0 when pressed; 0 means it reads 1 when pressed.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 btn_in  input  1  SHALL be the raw, asynchronous, bouncing push-button signal.
REQ-006 btn_level  output  1  SHALL be the debounced level, 1 = pressed, registered.
REQ-007 press_pulse  output  1  SHALL be a one-cycle registered strobe on an accepted press, sized to drive the en input of a downstream register.
REQ-008 release_pulse  output  1  SHALL be a one-cycle registered strobe on an accepted release.

Function
REQ-009 btn_in SHALL pass through a two-flop synchronizer after polarity normalisation; s = synchronized value, 1 = pressed.
REQ-010 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-011 IDLE: s=1 SHALL clear the counter and move to PRESS_WAIT; otherwise stay.
REQ-012 PRESS_WAIT: s=0 SHALL return to IDLE with no output; s=1 and cnt<DEBOUNCE_CYCLES-1 SHALL increment cnt; s=1 and cnt=DEBOUNCE_CYCLES-1 SHALL move to PRESSED and set press_pulse for the following cycle.
REQ-013 PRESSED: s=0 SHALL clear the counter and move to RELEASE_WAIT; otherwise stay.
REQ-014 RELEASE_WAIT: s=1 SHALL return to PRESSED with no pulse; s=0 and cnt<DEBOUNCE_CYCLES-1 SHALL increment cnt; s=0 and cnt=DEBOUNCE_CYCLES-1 SHALL move to IDLE and set release_pulse for the following cycle.
REQ-015 btn_level SHALL be 1 exactly while the state is PRESSED or RELEASE_WAIT.
REQ-016 Latency: for a press held stable from rising edge 0, press_pulse and btn_level SHALL go high right after edge DEBOUNCE_CYCLES+2; release is symmetric.
REQ-017 Any pulse on s shorter than DEBOUNCE_CYCLES cycles SHALL produce no pulse and no btn_level change.
REQ-018 press_pulse and release_pulse SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per accepted event.
REQ-019 A held button SHALL produce exactly one press_pulse, with no auto-repeat.
REQ-020 The counter SHALL be $clog2(DEBOUNCE_CYCLES) bits wide and SHALL never wrap; it is compared, not overflowed.

Reset
REQ-021 rst=0 SHALL immediately force state IDLE, cnt 0, synchronizer flops to "released", and btn_level, press_pulse and release_pulse to 0, regardless of clk.
REQ-022 Reset asserted mid-debounce or while PRESSED SHALL discard the event without any pulse.
REQ-023 After rst releases with the button already held, a press SHALL be accepted normally after the full REQ-016 latency.

Structure
REQ-024 The state enum typedef SHALL live in the shared package, as debounce_state_t.
REQ-025 The synchronizer SHALL be a separate sub-module, sync_2ff (clk, rst, d, q), reusable for other asynchronous board inputs.
REQ-026 The FSM, counter and output registers SHALL reside in button_debounce.

Verification (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, clk period 10)
REQ-027 Reset: rst=0 with btn_in=0 -> all outputs 0; after rst=1 with the button still held, press_pulse appears one cycle right after edge 6 and btn_level=1.
REQ-028 Clean press: btn_in goes 1->0 and is held -> exactly one press_pulse, right after edge 6; btn_level stays 1 while held, with no further pulses.
REQ-029 Bounce: btn_in toggles 0/1/0/1 every 2 cycles, then held 0 -> no output during bouncing; one press_pulse 7 cycles after the final stable transition.
REQ-030 Glitch: btn_in low for 3 cycles only -> no press_pulse; btn_level stays 0.
REQ-031 Release: after an accepted press, btn_in=1 held -> release_pulse one cycle right after edge 6 and btn_level=0; a 2-cycle release glitch -> no release_pulse, btn_level stays 1.
REQ-032 Integration: press_pulse drives a 4-bit register's en with switches 4'h9 -> the register and its 7-seg decode update exactly once per accepted press.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Shared types and helpers for the push-button debouncer and the logic
// that consumes its strobes.
package button_debounce_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
   localparam int MIN_DEBOUNCE_CYCLES     = 2;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } debounce_state_t;

   // The debounced level stays asserted until a release has been accepted.
   function automatic logic state_is_pressed(input debounce_state_t st);
      return (st == PRESSED) || (st == RELEASE_WAIT);
   endfunction

   // Segment order is {g,f,e,d,c,b,a}, active-high.
   function automatic logic [6:0] seg7_decode(input logic [3:0] value);
      logic [6:0] seg;
      seg = 7'h00;
      case (value)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Button-side bundle: raw input from the board plus the debounced level and
// press/release strobes returned to the consumer.
interface button_debounce_if;

   logic btn_in;
   logic btn_level;
   logic press_pulse;
   logic release_pulse;

   modport master (
      output btn_in,
      input  btn_level,
      input  press_pulse,
      input  release_pulse
   );

   modport slave (
      input  btn_in,
      output btn_level,
      output press_pulse,
      output release_pulse
   );

endinterface

// File: rtl/button_debounce_sync.sv
// Two-flop synchronizer for any asynchronous board input; the reset value is
// the input's idle level so no spurious edge follows reset.
module sync_2ff #(
   parameter bit RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= RESET_VALUE;
         q    <= RESET_VALUE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: polarity normalisation, 2-flop sync, then a
// four-state FSM that accepts a level only after DEBOUNCE_CYCLES stable cycles.
module button_debounce
   import button_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   button_debounce_if.slave   bus
);

   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             raw_pressed;
   logic             s;
   debounce_state_t  state;
   logic [CNT_W-1:0] cnt;
   logic             btn_level_r;
   logic             press_pulse_r;
   logic             release_pulse_r;

   assign raw_pressed = ACTIVE_LOW ? ~bus.btn_in : bus.btn_in;

   sync_2ff #(
      .RESET_VALUE (1'b0)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (raw_pressed),
      .q   (s)
   );

   // The counter only ever counts up to CNT_MAX and is cleared on entry to a
   // wait state, so it is compared rather than allowed to overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         cnt             <= '0;
         btn_level_r     <= 1'b0;
         press_pulse_r   <= 1'b0;
         release_pulse_r <= 1'b0;
      end else begin
         press_pulse_r   <= 1'b0;
         release_pulse_r <= 1'b0;
         case (state)
            IDLE: begin
               if (s) begin
                  cnt   <= '0;
                  state <= PRESS_WAIT;
               end
            end
            PRESS_WAIT: begin
               if (!s) begin
                  state <= IDLE;
               end else if (cnt == CNT_MAX) begin
                  state         <= PRESSED;
                  press_pulse_r <= 1'b1;
                  btn_level_r   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (!s) begin
                  cnt   <= '0;
                  state <= RELEASE_WAIT;
               end
            end
            RELEASE_WAIT: begin
               if (s) begin
                  state <= PRESSED;
               end else if (cnt == CNT_MAX) begin
                  state           <= IDLE;
                  release_pulse_r <= 1'b1;
                  btn_level_r     <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               cnt         <= '0;
               btn_level_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.btn_level     = btn_level_r;
   assign bus.press_pulse   = press_pulse_r;
   assign bus.release_pulse = release_pulse_r;

`ifndef SYNTHESIS
   pulse_exclusive: assert property (@(posedge clk) disable iff (!rst)
      !(press_pulse_r && release_pulse_r));
   level_matches_state: assert property (@(posedge clk) disable iff (!rst)
      btn_level_r == state_is_pressed(state));
   cnt_bounded: assert property (@(posedge clk) disable iff (!rst)
      cnt <= CNT_MAX);
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, active-low button,
// plus a 4-bit display register enabled by press_pulse.
module tb_button_debounce;
   import button_debounce_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;
   int   press_cnt   = 0;
   int   release_cnt = 0;

   button_debounce_if bus();

   button_debounce #(
      .DEBOUNCE_CYCLES (4),
      .ACTIVE_LOW      (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.press_pulse)   press_cnt   <= press_cnt + 1;
      if (bus.release_pulse) release_cnt <= release_cnt + 1;
   end

   // Downstream consumer: a switch register loaded by the press strobe.
   logic [3:0] switches = 4'h9;
   logic [3:0] shown;
   logic [6:0] seg;
   logic       int_clr = 1'b0;
   int         loads;

   always_ff @(posedge clk) begin
      if (int_clr) begin
         shown <= 4'h0;
         loads <= 0;
      end else if (bus.press_pulse) begin
         shown <= switches;
         loads <= loads + 1;
      end
   end

   assign seg = seg7_decode(shown);

   task automatic test_reset();
      bus.btn_in = 1'b0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (bus.btn_level !== 1'b0 || bus.press_pulse !== 1'b0 || bus.release_pulse !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs got lvl=%b prs=%b rel=%b want 000", bus.btn_level, bus.press_pulse, bus.release_pulse);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (bus.press_pulse !== (k == 6) || bus.btn_level !== (k >= 6)) begin
            miscompares++;
            $display("[TB] FAIL reset_held_press edge %0d got prs=%b lvl=%b want prs=%b lvl=%b", k, bus.press_pulse, bus.btn_level, (k == 6), (k >= 6));
         end
      end
   endtask

   task automatic test_release();
      int rel_before;
      rel_before = release_cnt;
      @(negedge clk);
      bus.btn_in = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (bus.release_pulse !== (k == 6) || bus.btn_level !== (k < 6) || bus.press_pulse !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL release edge %0d got rel=%b lvl=%b prs=%b want rel=%b lvl=%b prs=0", k, bus.release_pulse, bus.btn_level, bus.press_pulse, (k == 6), (k < 6));
         end
      end
      @(negedge clk);
      vectors++;
      if (release_cnt !== rel_before + 1) begin
         miscompares++;
         $display("[TB] FAIL release_count got %0d want %0d", release_cnt - rel_before, 1);
      end
   endtask

   task automatic test_clean_press();
      int prs_before;
      prs_before = press_cnt;
      @(negedge clk);
      bus.btn_in = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (bus.press_pulse !== (k == 6) || bus.btn_level !== (k >= 6)) begin
            miscompares++;
            $display("[TB] FAIL clean_press edge %0d got prs=%b lvl=%b want prs=%b lvl=%b", k, bus.press_pulse, bus.btn_level, (k == 6), (k >= 6));
         end
      end
      repeat (12) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (press_cnt !== prs_before + 1 || bus.btn_level !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL held_no_repeat got pulses=%0d lvl=%b want pulses=1 lvl=1", press_cnt - prs_before, bus.btn_level);
      end
   endtask

   task automatic test_release_glitch();
      @(negedge clk);
      bus.btn_in = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (bus.release_pulse !== 1'b0 || bus.btn_level !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL release_glitch edge %0d got rel=%b lvl=%b want rel=0 lvl=1", k, bus.release_pulse, bus.btn_level);
         end
         if (k == 1) begin
            @(negedge clk);
            bus.btn_in = 1'b0;
         end
      end
   endtask

   task automatic test_glitch();
      @(negedge clk);
      bus.btn_in = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (bus.press_pulse !== 1'b0 || bus.btn_level !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL press_glitch edge %0d got prs=%b lvl=%b want prs=0 lvl=0", k, bus.press_pulse, bus.btn_level);
         end
         if (k == 2) begin
            @(negedge clk);
            bus.btn_in = 1'b1;
         end
      end
   endtask

   task automatic test_bounce();
      logic [7:0] pattern;
      pattern = 8'hCC;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         bus.btn_in = pattern[k];
         @(posedge clk);
         #1;
         vectors++;
         if (bus.press_pulse !== 1'b0 || bus.btn_level !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bounce_quiet edge %0d got prs=%b lvl=%b want prs=0 lvl=0", k, bus.press_pulse, bus.btn_level);
         end
      end
      @(negedge clk);
      bus.btn_in = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (bus.press_pulse !== (k == 6) || bus.btn_level !== (k >= 6)) begin
            miscompares++;
            $display("[TB] FAIL bounce_settle edge %0d got prs=%b lvl=%b want prs=%b lvl=%b", k, bus.press_pulse, bus.btn_level, (k == 6), (k >= 6));
         end
      end
   endtask

   task automatic test_reset_mid();
      int rel_before;
      @(negedge clk);
      bus.btn_in = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      vectors++;
      if (bus.btn_level !== 1'b0 || bus.press_pulse !== 1'b0 || bus.release_pulse !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL async_reset_mid got lvl=%b prs=%b rel=%b want 000", bus.btn_level, bus.press_pulse, bus.release_pulse);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (bus.press_pulse !== (k == 6) || bus.btn_level !== (k >= 6)) begin
            miscompares++;
            $display("[TB] FAIL press_after_reset edge %0d got prs=%b lvl=%b want prs=%b lvl=%b", k, bus.press_pulse, bus.btn_level, (k == 6), (k >= 6));
         end
      end
      rel_before = release_cnt;
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      vectors++;
      if (bus.btn_level !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL async_reset_pressed got lvl=%b want 0", bus.btn_level);
      end
      bus.btn_in = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (release_cnt !== rel_before || bus.btn_level !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_discard got rel_pulses=%0d lvl=%b want 0 0", release_cnt - rel_before, bus.btn_level);
      end
   endtask

   task automatic test_integration();
      @(negedge clk);
      int_clr = 1'b1;
      @(negedge clk);
      int_clr = 1'b0;
      vectors++;
      if (shown !== 4'h0 || seg !== 7'h3F) begin
         miscompares++;
         $display("[TB] FAIL display_clear got reg=%h seg=%h want reg=0 seg=3f", shown, seg);
      end
      test_clean_press();
      vectors++;
      if (shown !== 4'h9 || seg !== 7'h6F || loads !== 1) begin
         miscompares++;
         $display("[TB] FAIL display_first got reg=%h seg=%h loads=%0d want reg=9 seg=6f loads=1", shown, seg, loads);
      end
      test_release();
      vectors++;
      if (loads !== 1) begin
         miscompares++;
         $display("[TB] FAIL display_on_release got loads=%0d want 1", loads);
      end
      test_clean_press();
      vectors++;
      if (shown !== 4'h9 || seg !== 7'h6F || loads !== 2) begin
         miscompares++;
         $display("[TB] FAIL display_second got reg=%h seg=%h loads=%0d want reg=9 seg=6f loads=2", shown, seg, loads);
      end
      test_release();
   endtask

   initial begin
      bus.btn_in = 1'b1;
      test_reset();
      test_release();
      test_clean_press();
      test_release_glitch();
      test_release();
      test_glitch();
      test_bounce();
      test_release();
      test_reset_mid();
      test_integration();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
